// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the telecommand frame decoder.
package cmd_frame_pkg;

  typedef enum logic [2:0] {
    StHunt0,
    StHunt1,
    StAddr,
    StDhi,
    StDlo,
    StCks,
    StWrite
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CKS  = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] HDR0_DEF = 8'hEB;
  localparam logic [7:0] HDR1_DEF = 8'h90;
  localparam int unsigned FRAME_LEN = 6;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-byte gap timer: pulses expire once the idle gap reaches TIMEOUT_CYC while running.
module frame_gap_timer #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clr,
  input  logic run,
  output logic expire
);

  logic [15:0] cnt_q;

  // Expiry is decoded from the held count so it wins over a byte arriving the same cycle.
  assign expire = run && (cnt_q == TIMEOUT_CYC);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= 16'd0;
    end else if (clr || !run || expire) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Validates HDR0 HDR1 ADDR DH DL CKS frames and issues one register write strobe per good frame.
module cmd_frame_decoder
  import cmd_frame_pkg::*;
#(
  parameter logic [7:0]  HDR0        = HDR0_DEF,
  parameter logic [7:0]  HDR1        = HDR1_DEF,
  parameter logic [7:0]  ADDR_MIN    = 8'h02,
  parameter logic [7:0]  ADDR_MAX    = 8'h15,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic        wr_out,
  output logic [7:0]  wr_addr_out,
  output logic [15:0] data_out,
  output logic [15:0] frame_ok_cnt_out,
  output logic [15:0] frame_err_cnt_out,
  output logic [1:0]  err_code_out,
  output logic        busy_out
);

  state_e      state_q;
  logic [7:0]  addr_sh_q, dh_sh_q, dl_sh_q;
  logic [7:0]  cks_sum;
  logic        tmo;
  logic        in_frame;

  assign in_frame = (state_q != StHunt0) && (state_q != StWrite);
  assign busy_out = in_frame;
  assign cks_sum  = addr_sh_q + dh_sh_q + dl_sh_q;

  frame_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .clr     (rx_valid_in),
    .run     (in_frame),
    .expire  (tmo)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q           <= StHunt0;
      addr_sh_q         <= 8'd0;
      dh_sh_q           <= 8'd0;
      dl_sh_q           <= 8'd0;
      wr_out            <= 1'b0;
      wr_addr_out       <= 8'd0;
      data_out          <= 16'd0;
      frame_ok_cnt_out  <= 16'd0;
      frame_err_cnt_out <= 16'd0;
      err_code_out      <= ERR_NONE;
    end else begin
      wr_out <= 1'b0;
      if (tmo) begin
        state_q           <= StHunt0;
        err_code_out      <= ERR_TMO;
        frame_err_cnt_out <= sat_inc(frame_err_cnt_out);
      end else if (rx_valid_in) begin
        case (state_q)
          // A byte landing in the WRITE cycle is hunted like any other.
          StHunt0, StWrite: state_q <= (rx_data_in == HDR0) ? StHunt1 : StHunt0;
          StHunt1: begin
            if (rx_data_in == HDR1)      state_q <= StAddr;
            else if (rx_data_in == HDR0) state_q <= StHunt1;
            else                         state_q <= StHunt0;
          end
          StAddr: begin
            addr_sh_q <= rx_data_in;
            state_q   <= StDhi;
          end
          StDhi: begin
            dh_sh_q <= rx_data_in;
            state_q <= StDlo;
          end
          StDlo: begin
            dl_sh_q <= rx_data_in;
            state_q <= StCks;
          end
          StCks: begin
            if (rx_data_in != cks_sum) begin
              state_q           <= StHunt0;
              err_code_out      <= ERR_CKS;
              frame_err_cnt_out <= sat_inc(frame_err_cnt_out);
            end else if ((addr_sh_q < ADDR_MIN) || (addr_sh_q > ADDR_MAX)) begin
              state_q           <= StHunt0;
              err_code_out      <= ERR_ADDR;
              frame_err_cnt_out <= sat_inc(frame_err_cnt_out);
            end else begin
              state_q          <= StWrite;
              wr_out           <= 1'b1;
              wr_addr_out      <= addr_sh_q;
              data_out         <= {dh_sh_q, dl_sh_q};
              frame_ok_cnt_out <= sat_inc(frame_ok_cnt_out);
            end
          end
          default: state_q <= StHunt0;
        endcase
      end else if (state_q == StWrite) begin
        state_q <= StHunt0;
      end
    end
  end

endmodule
